// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared FSM state encoding, default parameters and ID width helper
// for the alu_mem_arbiter block.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        GRANT_RD = 2'b01,
        GRANT_WR = 2'b10
    } arb_state_e;

    localparam int NUM_REQ_DEF    = 2;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int TIMEOUT_DEF    = 1024;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_mem_arbiter_if.sv
// alu_mem_arbiter_if: requester-side and memory-master-side signals of the arbiter;
// master = arbiter view, slave = environment (requesters + AXI master control) view.
interface alu_mem_arbiter_if #(
    parameter int NUM_REQ    = alu_arb_pkg::NUM_REQ_DEF,
    parameter int ADDR_WIDTH = alu_arb_pkg::ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = alu_arb_pkg::DATA_WIDTH_DEF,
    parameter int ID_W       = alu_arb_pkg::id_w(NUM_REQ)
);
    logic [NUM_REQ-1:0]            rq_read_req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] rq_read_addr;
    logic [DATA_WIDTH-1:0]         rq_read_data;
    logic [NUM_REQ-1:0]            rq_read_done;
    logic [NUM_REQ-1:0]            rq_write_req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] rq_write_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] rq_write_data;
    logic [NUM_REQ-1:0]            rq_write_done;
    logic                          m_read_req;
    logic [ADDR_WIDTH-1:0]         m_read_addr;
    logic [DATA_WIDTH-1:0]         m_read_data;
    logic                          m_read_done;
    logic                          m_write_req;
    logic [ADDR_WIDTH-1:0]         m_write_addr;
    logic [DATA_WIDTH-1:0]         m_write_data;
    logic                          m_write_done;
    logic [ID_W-1:0]               grant_id;
    logic                          arb_busy;
    logic                          arb_timeout;

    modport master (
        input  rq_read_req, rq_read_addr, rq_write_req, rq_write_addr, rq_write_data,
               m_read_data, m_read_done, m_write_done,
        output rq_read_data, rq_read_done, rq_write_done, m_read_req, m_read_addr,
               m_write_req, m_write_addr, m_write_data, grant_id, arb_busy, arb_timeout
    );

    modport slave (
        output rq_read_req, rq_read_addr, rq_write_req, rq_write_addr, rq_write_data,
               m_read_data, m_read_done, m_write_done,
        input  rq_read_data, rq_read_done, rq_write_done, m_read_req, m_read_addr,
               m_write_req, m_write_addr, m_write_data, grant_id, arb_busy, arb_timeout
    );
endinterface

// File: rtl/alu_arb_rr_pick.sv
// alu_arb_rr_pick: combinational round-robin picker; first set bit of req at or
// above ptr, wrapping NUM_REQ-1 -> 0.
module alu_arb_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid,
    output logic [ID_W-1:0]    idx
);
    logic [ID_W-1:0] k;

    // Scan farthest-first so the candidate closest to ptr is written last.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        k     = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (req[k]) begin
                valid = 1'b1;
                idx   = k;
            end
        end
    end
endmodule

// File: rtl/alu_mem_arbiter.sv
// alu_mem_arbiter: round-robin arbiter of NUM_REQ requesters onto one memory port,
// one transaction at a time, read before write. ARB_TIMEOUT_EN adds a grant watchdog.
module alu_mem_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEF,
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input logic ACLK,
    input logic ARESETN,
    alu_mem_arbiter_if.master bus
);
    localparam int ID_W = id_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("alu_mem_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    arb_state_e state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, pick_idx, next_ptr;
    logic busy_q, busy_d, rd_req_q, rd_req_d, wr_req_q, wr_req_d, timeout_q, timeout_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, waddr_q, waddr_d, sel_raddr, sel_waddr;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, sel_wdata;
    logic [NUM_REQ-1:0] grant_oh;
    logic pick_valid, sel_rd, rd_done, wr_done, timeout_hit;

    alu_arb_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req  (bus.rq_read_req | bus.rq_write_req),
        .ptr  (rr_ptr_q),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    always_comb begin
        sel_rd    = 1'b0;
        sel_raddr = '0;
        sel_waddr = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == pick_idx) begin
                sel_rd    = bus.rq_read_req[i];
                sel_raddr = bus.rq_read_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_waddr = bus.rq_write_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.rq_write_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rd_done  = (state_q == GRANT_RD) && bus.m_read_done;
    assign wr_done  = (state_q == GRANT_WR) && bus.m_write_done;
    assign grant_oh = NUM_REQ'(1) << grant_id_q;
    assign next_ptr = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_q, wd_d;
    assign timeout_hit = (state_q != IDLE) && !rd_done && !wr_done &&
                         (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign wd_d = (state_q != IDLE && state_d != IDLE) ? wd_q + 1'b1 : '0;
    always_ff @(posedge ACLK or negedge ARESETN)
        if (!ARESETN) wd_q <= '0;
        else          wd_q <= wd_d;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        rd_req_d   = rd_req_q;
        wr_req_d   = wr_req_q;
        raddr_d    = raddr_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        timeout_d  = timeout_hit;
        if (state_q == IDLE && pick_valid) begin
            state_d    = sel_rd ? GRANT_RD : GRANT_WR;
            grant_id_d = pick_idx;
            busy_d     = 1'b1;
            rd_req_d   = sel_rd;
            wr_req_d   = !sel_rd;
            raddr_d    = sel_rd ? sel_raddr : raddr_q;
            waddr_d    = sel_rd ? waddr_q : sel_waddr;
            wdata_d    = sel_rd ? wdata_q : sel_wdata;
        end else if (rd_done || wr_done || timeout_hit) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
            busy_d   = 1'b0;
            rd_req_d = 1'b0;
            wr_req_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            rd_req_q   <= rd_req_d;
            wr_req_q   <= wr_req_d;
            raddr_q    <= raddr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.rq_read_data  = bus.m_read_data;
    assign bus.rq_read_done  = rd_done ? grant_oh : '0;
    assign bus.rq_write_done = wr_done ? grant_oh : '0;
    assign bus.m_read_req    = rd_req_q;
    assign bus.m_read_addr   = raddr_q;
    assign bus.m_write_req   = wr_req_q;
    assign bus.m_write_addr  = waddr_q;
    assign bus.m_write_data  = wdata_q;
    assign bus.grant_id      = grant_id_q;
    assign bus.arb_busy      = busy_q;
    assign bus.arb_timeout   = timeout_q;
endmodule

// File: tb/tb_alu_mem_arbiter.sv
// tb_alu_mem_arbiter: directed and randomized checks of alu_mem_arbiter against a
// pending-request / round-robin-pointer reference model (ARB_TIMEOUT_EN aware).
module tb_alu_mem_arbiter;
    import alu_arb_pkg::*;
    localparam int N = 2, AW = 32, DW = 32, TO = 16, IW = id_w(N);

    logic ACLK = 1'b0, ARESETN = 1'b1;
    always #5 ACLK = ~ACLK;

    alu_mem_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    alu_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .bus(bus)
    );

    int vectors = 0, miscompares = 0, ptr = 0;
    bit rd_p[N], wr_p[N];
    logic [AW-1:0] ra[N], wa[N];
    logic [DW-1:0] wd[N];

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.rq_read_req[i] = rd_p[i];
            bus.rq_write_req[i] = wr_p[i];
            bus.rq_read_addr[i*AW +: AW] = ra[i];
            bus.rq_write_addr[i*AW +: AW] = wa[i];
            bus.rq_write_data[i*DW +: DW] = wd[i];
        end
    endtask

    function automatic int model_pick();
        for (int k = 0; k < N; k++)
            if (rd_p[(ptr + k) % N] || wr_p[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic serve(input int eg, input bit er, input int lat);
        int w = 0;
        logic [DW-1:0] rdat;
        logic [N-1:0] oh;
        oh = N'(1) << eg;
        while (!(bus.m_read_req || bus.m_write_req) && w < 20) begin tick(); w++; end
        vectors++;
        if (w != 1) begin miscompares++; $display("FAIL issue_latency: got %0d cycles want 1", w); end
        vectors++;
        if (bus.grant_id !== IW'(eg) || bus.arb_busy !== 1'b1 || {bus.m_read_req, bus.m_write_req} !== {er, !er}) begin
            miscompares++;
            $display("FAIL grant: got id=%0d busy=%b rd=%b wr=%b want id=%0d busy=1 rd=%b wr=%b",
                     bus.grant_id, bus.arb_busy, bus.m_read_req, bus.m_write_req, eg, er, !er);
        end
        vectors++;
        if (er ? (bus.m_read_addr !== ra[eg]) : (bus.m_write_addr !== wa[eg] || bus.m_write_data !== wd[eg])) begin
            miscompares++;
            $display("FAIL latched: got raddr=%h waddr=%h wdata=%h want raddr=%h waddr=%h wdata=%h",
                     bus.m_read_addr, bus.m_write_addr, bus.m_write_data, ra[eg], wa[eg], wd[eg]);
        end
        repeat (lat) begin
            tick();
            vectors++;
            if ({bus.m_read_req, bus.m_write_req} !== {er, !er} || (bus.rq_read_done | bus.rq_write_done) !== '0) begin
                miscompares++;
                $display("FAIL hold: got rd=%b wr=%b dones=%b/%b want rd=%b wr=%b dones=0",
                         bus.m_read_req, bus.m_write_req, bus.rq_read_done, bus.rq_write_done, er, !er);
            end
        end
        rdat = $urandom;
        if (er) begin bus.m_read_data = rdat; bus.m_read_done = 1'b1; end
        else bus.m_write_done = 1'b1;
        #1;
        vectors++;
        if (bus.rq_read_done !== (er ? oh : '0) || bus.rq_write_done !== (er ? '0 : oh) ||
            (er && bus.rq_read_data !== rdat)) begin
            miscompares++;
            $display("FAIL done_pulse: got rd_done=%b wr_done=%b data=%h want rd_done=%b wr_done=%b data=%h",
                     bus.rq_read_done, bus.rq_write_done, bus.rq_read_data, er ? oh : '0, er ? '0 : oh, rdat);
        end
        if (er) rd_p[eg] = 1'b0; else wr_p[eg] = 1'b0;
        apply();
        tick();
        bus.m_read_done = 1'b0;
        bus.m_write_done = 1'b0;
        vectors++;
        if ({bus.m_read_req, bus.m_write_req, bus.arb_busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL release: got rd=%b wr=%b busy=%b want 000", bus.m_read_req, bus.m_write_req, bus.arb_busy);
        end
        ptr = (eg + 1) % N;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) begin rd_p[i] = 0; wr_p[i] = 0; ra[i] = '0; wa[i] = '0; wd[i] = '0; end
        apply();
        bus.m_read_data = '0; bus.m_read_done = 1'b0; bus.m_write_done = 1'b0;
        #1 ARESETN = 1'b0;
        #1;
        vectors++;
        if ({bus.m_read_req, bus.m_write_req, bus.arb_busy, bus.arb_timeout} !== 4'b0 || bus.grant_id !== '0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got rd=%b wr=%b busy=%b to=%b id=%0d want all 0",
                     bus.m_read_req, bus.m_write_req, bus.arb_busy, bus.arb_timeout, bus.grant_id);
        end
        vectors++;
        if ({bus.m_read_addr, bus.m_write_addr, bus.m_write_data} !== '0 || (bus.rq_read_done | bus.rq_write_done) !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got raddr=%h waddr=%h wdata=%h want 0", bus.m_read_addr, bus.m_write_addr, bus.m_write_data);
        end
        tick(); tick();
        ARESETN = 1'b1;
        ptr = 0;
        repeat (3) tick();
        vectors++;
        if ({bus.m_read_req, bus.m_write_req, bus.arb_busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_no_req: got rd=%b wr=%b busy=%b want 000", bus.m_read_req, bus.m_write_req, bus.arb_busy);
        end
    endtask

    task automatic test_single();
        rd_p[1] = 1; ra[1] = 32'h8000_0010;
        apply();
        serve(1, 1'b1, 3);
    endtask

    task automatic test_contention();
        rd_p[0] = 1; ra[0] = $urandom; rd_p[1] = 1; ra[1] = $urandom;
        apply();
        serve(0, 1'b1, 1);
        rd_p[0] = 1; ra[0] = $urandom; apply();
        serve(1, 1'b1, 2);
        serve(0, 1'b1, 0);
        rd_p[0] = 1; ra[0] = $urandom; rd_p[1] = 1; ra[1] = $urandom; apply();
        serve(1, 1'b1, 1);
        serve(0, 1'b1, 1);
    endtask

    task automatic test_read_write_same();
        rd_p[0] = 1; ra[0] = 32'h8000_0004;
        wr_p[0] = 1; wa[0] = 32'h8000_0008; wd[0] = 32'hDEAD_BEEF;
        apply();
        serve(0, 1'b1, 2);
        serve(0, 1'b0, 2);
    endtask

    task automatic test_stray();
        bus.m_write_done = 1'b1;
        bus.m_read_done = 1'b1;
        #1;
        vectors++;
        if ((bus.rq_read_done | bus.rq_write_done) !== '0) begin
            miscompares++;
            $display("FAIL stray_idle: got rd_done=%b wr_done=%b want 0", bus.rq_read_done, bus.rq_write_done);
        end
        tick();
        bus.m_write_done = 1'b0;
        bus.m_read_done = 1'b0;
        vectors++;
        if ({bus.m_read_req, bus.m_write_req, bus.arb_busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL stray_idle_state: got rd=%b wr=%b busy=%b want 000", bus.m_read_req, bus.m_write_req, bus.arb_busy);
        end
        rd_p[1] = 1; ra[1] = $urandom; apply();
        tick();
        bus.m_write_done = 1'b1;
        #1;
        vectors++;
        if ((bus.rq_read_done | bus.rq_write_done) !== '0) begin
            miscompares++;
            $display("FAIL stray_grant: got rd_done=%b wr_done=%b want 0", bus.rq_read_done, bus.rq_write_done);
        end
        tick();
        bus.m_write_done = 1'b0;
        vectors++;
        if ({bus.m_read_req, bus.m_write_req, bus.arb_busy} !== 3'b101 || bus.grant_id !== IW'(1) || bus.m_read_addr !== ra[1]) begin
            miscompares++;
            $display("FAIL stray_grant_state: got rd=%b wr=%b busy=%b id=%0d want rd=1 wr=0 busy=1 id=1",
                     bus.m_read_req, bus.m_write_req, bus.arb_busy, bus.grant_id);
        end
        bus.m_read_done = 1'b1;
        #1;
        vectors++;
        if (bus.rq_read_done !== 2'b10) begin
            miscompares++;
            $display("FAIL stray_complete: got rd_done=%b want 10", bus.rq_read_done);
        end
        rd_p[1] = 0; apply();
        tick();
        bus.m_read_done = 1'b0;
        ptr = 0;
    endtask

    task automatic test_async_reset();
        wr_p[0] = 1; wa[0] = $urandom; wd[0] = $urandom; apply();
        tick();
        vectors++;
        if (bus.m_write_req !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_setup: got wr=%b want 1", bus.m_write_req);
        end
        #2 ARESETN = 1'b0;
        bus.m_write_done = 1'b1;
        #1;
        vectors++;
        if ({bus.m_write_req, bus.arb_busy} !== 2'b00 || bus.rq_write_done !== '0 || bus.grant_id !== '0) begin
            miscompares++;
            $display("FAIL areset_abort: got wr=%b busy=%b wr_done=%b id=%0d want 0 0 0 0",
                     bus.m_write_req, bus.arb_busy, bus.rq_write_done, bus.grant_id);
        end
        tick();
        bus.m_write_done = 1'b0;
        wr_p[0] = 0; apply();
        ARESETN = 1'b1;
        ptr = 0;
        tick();
        rd_p[1] = 1; ra[1] = $urandom; apply();
        serve(1, 1'b1, 2);
    endtask

    task automatic test_timeout();
        int hold;
        rd_p[0] = 1; ra[0] = $urandom; rd_p[1] = 1; ra[1] = $urandom; apply();
        tick();
        vectors++;
        if (bus.m_read_req !== 1'b1 || bus.grant_id !== '0) begin
            miscompares++;
            $display("FAIL wd_grant: got rd=%b id=%0d want 1 0", bus.m_read_req, bus.grant_id);
        end
`ifdef ARB_TIMEOUT_EN
        hold = TO;
`else
        hold = 40;
`endif
        for (int k = 1; k <= hold; k++) begin
            tick();
            vectors++;
`ifdef ARB_TIMEOUT_EN
            if (bus.arb_timeout !== (k == TO) || bus.m_read_req !== (k != TO) || bus.rq_read_done !== '0) begin
                miscompares++;
                $display("FAIL wd_cycle%0d: got to=%b rd=%b rd_done=%b want to=%b rd=%b rd_done=0",
                         k, bus.arb_timeout, bus.m_read_req, bus.rq_read_done, k == TO, k != TO);
            end
`else
            if (bus.arb_timeout !== 1'b0 || bus.m_read_req !== 1'b1 || bus.grant_id !== '0) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: got to=%b rd=%b id=%0d want 0 1 0", k, bus.arb_timeout, bus.m_read_req, bus.grant_id);
            end
`endif
        end
`ifdef ARB_TIMEOUT_EN
        tick();
        vectors++;
        if (bus.arb_timeout !== 1'b0 || bus.m_read_req !== 1'b1 || bus.grant_id !== IW'(1) || bus.m_read_addr !== ra[1]) begin
            miscompares++;
            $display("FAIL wd_next: got to=%b rd=%b id=%0d want 0 1 1", bus.arb_timeout, bus.m_read_req, bus.grant_id);
        end
        bus.m_read_done = 1'b1;
        rd_p[1] = 0; apply();
        tick();
        bus.m_read_done = 1'b0;
        ptr = 0;
        serve(0, 1'b1, 1);
`else
        bus.m_read_done = 1'b1;
        #1;
        vectors++;
        if (bus.rq_read_done !== 2'b01) begin
            miscompares++;
            $display("FAIL hold_done: got rd_done=%b want 01", bus.rq_read_done);
        end
        rd_p[0] = 0; apply();
        tick();
        bus.m_read_done = 1'b0;
        ptr = 1;
        serve(1, 1'b1, 0);
`endif
    endtask

    task automatic test_random();
        int g;
        for (int t = 0; t < 200; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!rd_p[i] && !wr_p[i]) begin
                    int c = $urandom_range(0, 3);
                    rd_p[i] = c[0]; wr_p[i] = c[1];
                    ra[i] = $urandom; wa[i] = $urandom; wd[i] = $urandom;
                end
            end
            if (model_pick() < 0) rd_p[$urandom_range(0, N - 1)] = 1;
            apply();
            g = model_pick();
            serve(g, rd_p[g], $urandom_range(0, 4));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_read_write_same();
        test_stray();
        test_async_reset();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_mem_arbiter.md
ALU_MEM_ARBITER -- requirements
Module: alu_mem_arbiter

Interface
REQ-001 NUM_REQ, default 2, number of CPU-controller requesters sharing one memory port (2..8); ID_W = max(1, clog2(NUM_REQ)).
REQ-002 ADDR_WIDTH, default 32, address width.
REQ-003 DATA_WIDTH, default 32, data width.
REQ-004 TIMEOUT_CYCLES, default 1024, watchdog limit (used only under ARB_TIMEOUT_EN).
REQ-005 ACLK  in  1  sole clock, rising edge.
REQ-006 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-007 rq_read_req  in  NUM_REQ  per-requester read request, held until its rq_read_done.
REQ-008 rq_read_addr  in  NUM_REQ*ADDR_WIDTH  packed read addresses, slot i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 rq_read_data  out  DATA_WIDTH  read data broadcast to all requesters (= m_read_data).
REQ-010 rq_read_done  out  NUM_REQ  one-cycle read-complete pulse to the granted requester only.
REQ-011 rq_write_req  in  NUM_REQ  per-requester write request, held until its rq_write_done.
REQ-012 rq_write_addr  in  NUM_REQ*ADDR_WIDTH  packed write addresses.
REQ-013 rq_write_data  in  NUM_REQ*DATA_WIDTH  packed write data.
REQ-014 rq_write_done  out  NUM_REQ  one-cycle write-complete pulse to the granted requester only.
REQ-015 m_read_req  out  1  read request to AXI master control.
REQ-016 m_read_addr  out  ADDR_WIDTH  latched read address.
REQ-017 m_read_data  in  DATA_WIDTH  read data from master.
REQ-018 m_read_done  in  1  read transaction complete pulse.
REQ-019 m_write_req  out  1  write request to AXI master control.
REQ-020 m_write_addr  out  ADDR_WIDTH  latched write address.
REQ-021 m_write_data  out  DATA_WIDTH  latched write data.
REQ-022 m_write_done  in  1  write transaction complete pulse.
REQ-023 grant_id  out  ID_W  index of current/last grantee.
REQ-024 arb_busy  out  1  high while a grant is outstanding.
REQ-025 arb_timeout  out  1  one-cycle pulse on watchdog abort (tied 0 without ARB_TIMEOUT_EN).

Function
REQ-026 FSM states IDLE, GRANT_RD, GRANT_WR; exactly one transaction outstanding at any time.
REQ-027 IDLE: candidates = requesters with rq_read_req or rq_write_req; round-robin pick starting at rr_ptr, searching upward with wrap NUM_REQ-1 -> 0.
REQ-028 Grantee with both read and write pending -> read granted first (GRANT_RD).
REQ-029 On grant, address/data of grantee latched into m_* registers; m_*_req asserted the next cycle (1-cycle request-to-issue latency), arb_busy=1, grant_id=grantee.
REQ-030 m_read_req/m_write_req held high, m_* addr/data stable, until matching m_*_done; a grantee dropping its request mid-grant has no effect.
REQ-031 On m_*_done in matching state: rq_*_done[grant_id] pulses combinationally same cycle, m_*_req deasserts next cycle, rr_ptr <= grant_id+1 (wrap), state -> IDLE.
REQ-032 m_*_done in IDLE or mismatched state is ignored; no rq_*_done generated.
REQ-033 New requests arriving in the done cycle are arbitrated next cycle in IDLE (minimum one idle cycle between transactions).
REQ-034 No requests: stay IDLE, all m_*_req low.

Reset
REQ-035 ARESETN low asynchronously forces IDLE, rr_ptr=0, grant_id=0, arb_busy=0, m_*_req=0, m_* addr/data=0, all done pulses and arb_timeout=0, watchdog=0; an in-flight transaction is abandoned with no done pulse.

Configuration
REQ-036 ARB_TIMEOUT_EN defined: counter runs in GRANT_*; reaching TIMEOUT_CYCLES without done -> arb_timeout pulse, m_*_req drop, no rq_*_done, rr_ptr advances, IDLE; undefined: no counter, grant held indefinitely.

Structure
REQ-037 Package alu_arb_pkg holds state encoding (IDLE=2'b00, GRANT_RD=2'b01, GRANT_WR=2'b10) and default parameter constants.
REQ-038 Combinational round-robin picker is sub-module alu_arb_rr_pick (req vector, ptr in; valid, index out).

Verification
REQ-039 Single: rq_read_req[1]=1, addr 0x80000010; m_read_done 3 cycles after m_read_req -> m_read_addr=0x80000010, rq_read_done[1] one pulse, rq_read_done[0]=0.
REQ-040 Contention: reads from 0 and 1 same cycle, rr_ptr=0 -> 0 served, then 1, then 0 again if it re-requests (alternation over 4 transactions).
REQ-041 Same requester read+write: read 0x80000004 and write 0x80000008/0xDEADBEEF -> read first, then write with m_write_data=0xDEADBEEF.
REQ-042 Stray m_write_done during GRANT_RD or IDLE -> no done pulse, state unchanged.
REQ-043 ARESETN low mid-GRANT_WR -> m_write_req=0 immediately (asynchronous), arb_busy=0, no done pulse; next request granted normally.
REQ-044 With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no done -> arb_timeout pulse 16 cycles after m_read_req rises, other pending requester then granted.
